// File: rtl/fmc150_spi_arb.sv
`default_nettype none
// ============================================================================
// Module   : fmc150_spi_arb
// Purpose  : Shared SPI master for the FMC150 control bus. Up to NREQ
//            on-chip requesters post 32-bit frames; a round-robin arbiter
//            picks one, the frame is shifted full-duplex MSB first (mode 0)
//            to one of four devices (CDC, ADC, DAC, MON), and the word
//            captured from SDI is handed back to the winning requester.
// Ports    : CLK, RST            - clock, synchronous active-high reset
//            req_valid/req_ready - per-requester handshake
//            req_dev/req_data    - per-requester device select and frame
//            rsp_valid/rsp_data  - completion pulse and captured word
//            busy                - high whenever a frame is in flight
//            spi_sclk/spi_sdo/spi_csb/spi_sdi - SPI pins
// Revision : 1.0 - initial release
// ============================================================================
module fmc150_spi_arb #(
   parameter int NREQ     = 2,
   parameter int CLKDIV   = 4,
   parameter int CS_SETUP = 2,
   parameter int CS_HOLD  = 2,
   parameter int CS_GAP   = 2
) (
   input  logic                CLK,
   input  logic                RST,
   input  logic [NREQ-1:0]     req_valid,
   output logic [NREQ-1:0]     req_ready,
   input  logic [2*NREQ-1:0]   req_dev,
   input  logic [32*NREQ-1:0]  req_data,
   output logic [NREQ-1:0]     rsp_valid,
   output logic [31:0]         rsp_data,
   output logic                busy,
   output logic                spi_sclk,
   output logic                spi_sdo,
   output logic [3:0]          spi_csb,
   input  logic                spi_sdi
);

   localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int DW = $clog2(2 * CLKDIV);
   localparam int CW = 16;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_SETUP = 3'd1,
      S_SHIFT = 3'd2,
      S_HOLD  = 3'd3,
      S_DONE  = 3'd4,
      S_GAP   = 3'd5
   } state_t;

   state_t           state;
   logic [GW-1:0]    last_grant;
   logic [GW-1:0]    grant;
   logic [GW-1:0]    winner;
   logic             found;
   logic [1:0]       sel_dev;
   logic [31:0]      sel_data;
   logic [NREQ-1:0]  grant_oh;
   logic [31:0]      shift_reg;
   logic [DW-1:0]    div_cnt;
   logic [4:0]       bit_cnt;
   logic [CW-1:0]    cnt;

   // Round-robin search: start one past the last grant and take the first
   // valid requester, wrapping modulo NREQ.
   always_comb begin
      int idx;
      idx    = 0;
      winner = last_grant;
      found  = 1'b0;
      for (int k = 1; k <= NREQ; k++) begin
         idx = (int'(last_grant) + k) % NREQ;
         for (int j = 0; j < NREQ; j++) begin
            if (!found && (j == idx) && req_valid[j]) begin
               found  = 1'b1;
               winner = GW'(j);
            end
         end
      end
   end

   // Payload mux for the current winner and one-hot of the latched grant.
   always_comb begin
      sel_dev  = '0;
      sel_data = '0;
      grant_oh = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (winner == GW'(i)) begin
            sel_dev  = req_dev[2*i +: 2];
            sel_data = req_data[32*i +: 32];
         end
         if (grant == GW'(i)) begin
            grant_oh[i] = 1'b1;
         end
      end
   end

   // Ready is the only combinational output; it is suppressed in the reset
   // cycle so a request can never be consumed while RST is high.
   generate
      for (genvar gi = 0; gi < NREQ; gi++) begin : g_ready
         assign req_ready[gi] = (state == S_IDLE) && !RST && found &&
                                (winner == GW'(gi));
      end
   endgenerate

   always_ff @(posedge CLK) begin
      if (RST) begin
         state      <= S_IDLE;
         last_grant <= GW'(NREQ - 1);
         grant      <= '0;
         shift_reg  <= '0;
         div_cnt    <= '0;
         bit_cnt    <= '0;
         cnt        <= '0;
         spi_csb    <= 4'hF;
         spi_sclk   <= 1'b0;
         spi_sdo    <= 1'b0;
         rsp_valid  <= '0;
         rsp_data   <= '0;
         busy       <= 1'b0;
      end else begin
         rsp_valid <= '0;
         case (state)
            S_IDLE: begin
               if (found) begin
                  grant      <= winner;
                  last_grant <= winner;
                  shift_reg  <= sel_data;
                  spi_sdo    <= sel_data[31];
                  spi_csb    <= ~(4'b0001 << sel_dev);
                  spi_sclk   <= 1'b0;
                  cnt        <= '0;
                  busy       <= 1'b1;
                  state      <= S_SETUP;
               end
            end

            S_SETUP: begin
               if (cnt == CW'(CS_SETUP - 1)) begin
                  div_cnt <= '0;
                  bit_cnt <= '0;
                  state   <= S_SHIFT;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end

            S_SHIFT: begin
               // Capture SDI at the end of the first SCLK-high cycle.
               if (div_cnt == DW'(CLKDIV)) begin
                  shift_reg <= {shift_reg[30:0], spi_sdi};
               end
               if (div_cnt == DW'(2 * CLKDIV - 1)) begin
                  div_cnt  <= '0;
                  spi_sclk <= 1'b0;
                  if (bit_cnt == 5'd31) begin
                     cnt   <= '0;
                     state <= S_HOLD;
                  end else begin
                     bit_cnt <= bit_cnt + 1'b1;
                     // When the capture lands on this same edge (CLKDIV=1)
                     // the next bit has not moved up to bit 31 yet.
                     spi_sdo <= (div_cnt == DW'(CLKDIV)) ? shift_reg[30]
                                                         : shift_reg[31];
                  end
               end else begin
                  div_cnt  <= div_cnt + 1'b1;
                  spi_sclk <= ((div_cnt + 1'b1) >= DW'(CLKDIV));
               end
            end

            S_HOLD: begin
               if (cnt == CW'(CS_HOLD - 1)) begin
                  spi_csb   <= 4'hF;
                  rsp_valid <= grant_oh;
                  rsp_data  <= shift_reg;
                  state     <= S_DONE;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end

            S_DONE: begin
               // DONE already counts as one CSB-high gap cycle.
               cnt <= '0;
               if (CS_GAP <= 1) begin
                  busy  <= 1'b0;
                  state <= S_IDLE;
               end else begin
                  state <= S_GAP;
               end
            end

            S_GAP: begin
               if (cnt >= CW'(CS_GAP - 2)) begin
                  busy  <= 1'b0;
                  state <= S_IDLE;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end

            default: begin
               spi_csb  <= 4'hF;
               spi_sclk <= 1'b0;
               busy     <= 1'b0;
               state    <= S_IDLE;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_fmc150_spi_arb.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_fmc150_spi_arb
// Purpose  : Directed self-checking bench for fmc150_spi_arb. One instance
//            uses default timing, a second the minimum-timing corner.
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_fmc150_spi_arb;

   logic        CLK = 1'b0;
   logic        RST = 1'b1;
   always #5 CLK = ~CLK;

   // default-parameter instance
   logic [1:0]  req_valid = '0;
   logic [1:0]  req_ready;
   logic [3:0]  req_dev   = '0;
   logic [63:0] req_data  = '0;
   logic [1:0]  rsp_valid;
   logic [31:0] rsp_data;
   logic        busy, sclk, sdo;
   logic [3:0]  csb;
   logic        sdi = 1'b1;

   // corner-parameter instance
   logic [1:0]  req_valid_c = '0;
   logic [1:0]  req_ready_c;
   logic [3:0]  req_dev_c   = '0;
   logic [63:0] req_data_c  = '0;
   logic [1:0]  rsp_valid_c;
   logic [31:0] rsp_data_c;
   logic        busy_c, sclk_c, sdo_c;
   logic [3:0]  csb_c;
   logic        sdi_c = 1'b1;

   fmc150_spi_arb u_dut (
      .CLK(CLK), .RST(RST),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_dev(req_dev), .req_data(req_data),
      .rsp_valid(rsp_valid), .rsp_data(rsp_data), .busy(busy),
      .spi_sclk(sclk), .spi_sdo(sdo), .spi_csb(csb), .spi_sdi(sdi)
   );

   fmc150_spi_arb #(.NREQ(2), .CLKDIV(1), .CS_SETUP(1), .CS_HOLD(1), .CS_GAP(1)) u_dut_c (
      .CLK(CLK), .RST(RST),
      .req_valid(req_valid_c), .req_ready(req_ready_c),
      .req_dev(req_dev_c), .req_data(req_data_c),
      .rsp_valid(rsp_valid_c), .rsp_data(rsp_data_c), .busy(busy_c),
      .spi_sclk(sclk_c), .spi_sdo(sdo_c), .spi_csb(csb_c), .spi_sdi(sdi_c)
   );

   int tests = 0;
   int fails = 0;
   int cyc   = 0;
   always @(posedge CLK) cyc <= cyc + 1;

   // SPI slave model: presents sdi_word MSB first, advancing on SCLK falls.
   logic [31:0] sdi_word = 32'hA5A50F0F;
   int          sdi_idx  = 0;
   logic        sclk_q   = 1'b0;
   always @(negedge CLK) begin
      if (&csb) sdi_idx = 0;
      else if (sclk_q && !sclk && sdi_idx < 31) sdi_idx++;
      sdi    = sdi_word[5'(31 - sdi_idx)];
      sclk_q = sclk;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Waits for the grant of 'req', then follows the frame to its rsp_valid.
   task automatic frame(input int req, input logic [1:0] dev, input logic [31:0] data,
                        input bit drop, output int n, output int rsp_cyc);
      int rises, first_rise, last_rise, per_err, csb_err, stab_err, both;
      logic [31:0] word;
      logic [1:0]  exp_oh;
      logic [3:0]  exp_csb;
      logic        prev_sdo, prev_sclk;
      exp_oh  = 2'b01 << req;
      exp_csb = ~(4'b0001 << dev);
      both = 0; rsp_cyc = -1;
      for (int k = 0; k < 600; k++) begin
         #1;
         if (req_ready == 2'b11) both++;
         if (req_ready != 2'b00) break;
         @(negedge CLK);
      end
      n = cyc;
      check("ready_grant", {30'd0, req_ready}, {30'd0, exp_oh});
      check("ready_onehot", both, 0);
      rises = 0; first_rise = -1; last_rise = -1; per_err = 0;
      csb_err = 0; stab_err = 0; word = '0;
      prev_sdo = sdo; prev_sclk = sclk;
      for (int k = 0; k < 400; k++) begin
         @(negedge CLK);
         if (k == 0 && drop) req_valid[req] = 1'b0;
         if (rsp_valid != 2'b00) begin
            rsp_cyc = cyc;
            break;
         end
         if (csb !== exp_csb) csb_err++;
         if (sclk && !prev_sclk) begin
            rises++;
            word = {word[30:0], sdo};
            if (sdo !== prev_sdo) stab_err++;
            if (first_rise < 0) first_rise = cyc;
            else if (cyc - last_rise != 8) per_err++;
            last_rise = cyc;
         end
         prev_sdo = sdo; prev_sclk = sclk;
      end
      check("rsp_cycle", rsp_cyc, n + 261);
      check("rsp_valid", {30'd0, rsp_valid}, {30'd0, exp_oh});
      check("csb_at_done", {28'd0, csb}, 32'hF);
      check("csb_low_errs", csb_err, 0);
      check("first_rise", first_rise, n + 7);
      check("sclk_rises", rises, 32);
      check("sclk_period_errs", per_err, 0);
      check("sdo_word", word, data);
      check("sdo_stable_errs", stab_err, 0);
      check("rsp_data", rsp_data, sdi_word);
   endtask

   initial begin
      int n, r, n_prev, r_prev, cnt_bad, rises, per_err, last_rise, first_rise, csb_err;
      logic [31:0] word;
      logic prev_sclk;

      // ---- reset state; a request presented during RST is not taken ----
      req_dev  = {2'd0, 2'd2};
      req_data = {32'h0, 32'h12345678};
      req_valid = 2'b01;
      repeat (3) @(negedge CLK);
      check("rst_csb", {28'd0, csb}, 32'hF);
      check("rst_sclk", {31'd0, sclk}, 32'd0);
      check("rst_sdo", {31'd0, sdo}, 32'd0);
      check("rst_rsp_valid", {30'd0, rsp_valid}, 32'd0);
      check("rst_rsp_data", rsp_data, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_ready", {30'd0, req_ready}, 32'd0);
      @(negedge CLK);
      check("rst_no_accept", {31'd0, busy}, 32'd0);
      RST = 1'b0;

      // ---- single write: requester 0 to DAC ----
      frame(0, 2'd2, 32'h12345678, 1'b1, n, r);

      // ---- read capture: requester 1 to CDC ----
      req_dev[3:2]    = 2'd0;
      req_data[63:32] = 32'hDEADBEEF;
      req_valid       = 2'b10;
      frame(1, 2'd0, 32'hDEADBEEF, 1'b1, n, r);

      // ---- contention right after reset ----
      @(negedge CLK);
      RST = 1'b1;
      req_dev   = {2'd3, 2'd1};
      req_data  = {32'h2222FFFF, 32'h11110000};
      req_valid = 2'b11;
      @(negedge CLK);
      #1;
      check("contention_rst_ready", {30'd0, req_ready}, 32'd0);
      RST = 1'b0;
      frame(0, 2'd1, 32'h11110000, 1'b0, n, r);
      r_prev = r;
      frame(1, 2'd3, 32'h2222FFFF, 1'b0, n, r);
      check("gap_accept_1", n, r_prev + 2);
      r_prev = r;
      frame(0, 2'd1, 32'h11110000, 1'b0, n, r);
      check("gap_accept_2", n, r_prev + 2);
      r_prev = r;
      frame(1, 2'd3, 32'h2222FFFF, 1'b0, n, r);
      check("gap_accept_3", n, r_prev + 2);
      req_valid = 2'b00;

      // ---- reset during bit 10 ----
      req_dev   = {2'd0, 2'd2};
      req_data  = {32'h3C3C3C3C, 32'h0F0F1234};
      req_valid = 2'b01;
      for (int k = 0; k < 600; k++) begin
         #1;
         if (req_ready != 2'b00) break;
         @(negedge CLK);
      end
      n_prev = cyc;
      check("midrst_grant", {30'd0, req_ready}, 32'd1);
      @(negedge CLK);
      req_valid = 2'b00;
      for (int k = 0; k < 200 && cyc < n_prev + 87; k++) @(negedge CLK);
      check("midrst_bit10_sclk", {31'd0, sclk}, 32'd1);
      RST = 1'b1;
      @(negedge CLK);
      check("midrst_csb", {28'd0, csb}, 32'hF);
      check("midrst_sclk", {31'd0, sclk}, 32'd0);
      check("midrst_busy", {31'd0, busy}, 32'd0);
      RST = 1'b0;
      cnt_bad = 0;
      for (int k = 0; k < 300; k++) begin
         @(negedge CLK);
         if (rsp_valid != 2'b00 || busy) cnt_bad++;
      end
      check("midrst_no_rsp", cnt_bad, 0);
      req_dev[3:2]    = 2'd0;
      req_data[63:32] = 32'h3C3C3C3C;
      req_valid       = 2'b10;
      frame(1, 2'd0, 32'h3C3C3C3C, 1'b1, n, r);

      // ---- minimum-timing corner ----
      req_dev_c   = {2'd0, 2'd3};
      req_data_c  = {32'h0, 32'hC0FFEE11};
      req_valid_c = 2'b01;
      for (int k = 0; k < 50; k++) begin
         #1;
         if (req_ready_c != 2'b00) break;
         @(negedge CLK);
      end
      n = cyc;
      check("c_grant", {30'd0, req_ready_c}, 32'd1);
      r = -1; rises = 0; per_err = 0; last_rise = -1; first_rise = -1; csb_err = 0;
      word = '0; prev_sclk = sclk_c;
      for (int k = 0; k < 200; k++) begin
         @(negedge CLK);
         if (rsp_valid_c != 2'b00) begin
            r = cyc;
            break;
         end
         if (csb_c !== 4'b0111) csb_err++;
         if (sclk_c && !prev_sclk) begin
            rises++;
            word = {word[30:0], sdo_c};
            if (first_rise < 0) first_rise = cyc;
            else if (cyc - last_rise != 2) per_err++;
            last_rise = cyc;
         end
         prev_sclk = sclk_c;
      end
      check("c_rsp_cycle", r, n + 67);
      check("c_rsp_valid", {30'd0, rsp_valid_c}, 32'd1);
      check("c_rsp_data", rsp_data_c, 32'hFFFFFFFF);
      check("c_first_rise", first_rise, n + 3);
      check("c_rises", rises, 32);
      check("c_period_errs", per_err, 0);
      check("c_csb_errs", csb_err, 0);
      check("c_sdo_word", word, 32'hC0FFEE11);
      n_prev = -1;
      for (int k = 0; k < 20; k++) begin
         @(negedge CLK);
         #1;
         if (req_ready_c != 2'b00) begin
            n_prev = cyc;
            break;
         end
      end
      check("c_next_accept", n_prev, n + 68);
      req_valid_c = 2'b00;
      @(negedge CLK);
      check("c_idle_after_drop", {31'd0, busy_c}, 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
`default_nettype wire
